cr_ifu_ex_issue: RTL and testbench



---
 rtl/cr_ifu_issue_pkg.sv | 32 +++
 rtl/cr_ifu_issue_entry.sv | 49 ++++
 rtl/cr_ifu_ex_issue.sv | 182 ++++++++++++++++++
 tb/tb_cr_ifu_ex_issue.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cr_ifu_issue_pkg.sv
// -----------------------------------------------------------------------------
// cr_ifu_issue_pkg
// Shared definitions for the IFU issue stage:
//   - default payload widths (instruction, halfword-aligned PC)
//   - issue-state encoding; bit 0 = EX valid, bit 1 = skid valid
//   - tag record and full entry record carried with each instruction
// Optional feature macro used by the top: CR_IFU_ISSUE_STALL_CNT_EN
// -----------------------------------------------------------------------------
package cr_ifu_issue_pkg;

   localparam int CR_INST_W = 32;
   localparam int CR_PC_W   = 31;

   // State encoding doubles as {skid_vld, ex_vld}
   localparam logic [1:0] ST_EMPTY   = 2'b00;
   localparam logic [1:0] ST_EX_ONLY = 2'b01;
   localparam logic [1:0] ST_FULL    = 2'b11;

   typedef struct packed {
      logic expt;      // fetch exception
      logic prvlg;     // privilege exception
      logic ni;        // non-interruptible
      logic rand_vld;  // internally injected op
   } issue_tag_t;

   typedef struct packed {
      logic [CR_INST_W-1:0] inst;
      logic [CR_PC_W-1:0]   pc;
      issue_tag_t           tag;
   } issue_entry_t;

endpackage

// File: rtl/cr_ifu_issue_entry.sv
// -----------------------------------------------------------------------------
// cr_ifu_issue_entry
// Tagged payload register with load enable. Holds one instruction, its PC and
// its tag bits. Contents change only when i_load is high; validity is tracked
// by the owner.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_load          capture i_inst/i_pc/i_tag this cycle
//   i_inst/i_pc/i_tag  incoming payload
//   o_inst/o_pc/o_tag  stored payload
// -----------------------------------------------------------------------------
module cr_ifu_issue_entry
   import cr_ifu_issue_pkg::*;
#(
   parameter int INST_W = CR_INST_W,
   parameter int PC_W   = CR_PC_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic [INST_W-1:0] i_inst,
   input  logic [PC_W-1:0]   i_pc,
   input  issue_tag_t        i_tag,
   output logic [INST_W-1:0] o_inst,
   output logic [PC_W-1:0]   o_pc,
   output issue_tag_t        o_tag
);

   logic [INST_W-1:0] r_inst;
   logic [PC_W-1:0]   r_pc;
   issue_tag_t        r_tag;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_inst <= '0;
         r_pc   <= '0;
         r_tag  <= '0;
      end else if (i_load) begin
         r_inst <= i_inst;
         r_pc   <= i_pc;
         r_tag  <= i_tag;
      end
   end

   assign o_inst = r_inst;
   assign o_pc   = r_pc;
   assign o_tag  = r_tag;

endmodule

// File: rtl/cr_ifu_ex_issue.sv
// -----------------------------------------------------------------------------
// cr_ifu_ex_issue
// IFU-side issue stage: EX register feeding the IU execute interface plus a
// one-entry skid buffer so that the ready back to the instruction buffer is a
// flop. Strict FIFO, at most two instructions in flight; flush empties both.
// Optional feature: define CR_IFU_ISSUE_STALL_CNT_EN to enable the saturating
// EX stall-cycle counter on ifu_issue_stall_cnt (tied to 0 otherwise).
// Ports:
//   forever_cpuclk, cpurst          clock, asynchronous active-high reset
//   ib_issue_*                      instruction offered by the IB
//   ifu_ib_issue_rdy                registered ready to the IB
//   iu_ifu_ex_stall, iu_ifu_flush   IU back-pressure and pipeline flush
//   ifu_iu_ex_*                     EX instruction, PC and tags to the IU
//   ifu_issue_stall_cnt             stall-cycle counter (optional feature)
// -----------------------------------------------------------------------------
module cr_ifu_ex_issue
   import cr_ifu_issue_pkg::*;
#(
   parameter int INST_W = CR_INST_W,
   parameter int PC_W   = CR_PC_W
) (
   input  logic              forever_cpuclk,
   input  logic              cpurst,
   input  logic              ib_issue_vld,
   input  logic [INST_W-1:0] ib_issue_inst,
   input  logic [PC_W-1:0]   ib_issue_pc,
   input  logic              ib_issue_expt_vld,
   input  logic              ib_issue_prvlg_expt_vld,
   input  logic              ib_issue_ni,
   input  logic              ib_issue_rand_vld,
   output logic              ifu_ib_issue_rdy,
   input  logic              iu_ifu_ex_stall,
   input  logic              iu_ifu_flush,
   output logic              ifu_iu_ex_inst_vld,
   output logic [INST_W-1:0] ifu_iu_ex_inst,
   output logic [PC_W-1:0]   ifu_iu_ex_pc,
   output logic              ifu_iu_ex_expt_vld,
   output logic              ifu_iu_ex_prvlg_expt_vld,
   output logic              ifu_iu_ex_ni,
   output logic              ifu_iu_ex_rand_vld,
   output logic [31:0]       ifu_issue_stall_cnt
);

   logic [1:0]        r_state;
   logic [1:0]        w_state_next;
   logic              r_rdy;
   logic              w_ex_vld;
   logic              w_accept;
   logic              w_advance;
   logic              w_ex_load;
   logic              w_skid_load;
   logic              w_ex_from_skid;

   issue_tag_t        w_ib_tag;
   logic [INST_W-1:0] w_skid_inst;
   logic [PC_W-1:0]   w_skid_pc;
   issue_tag_t        w_skid_tag;
   logic [INST_W-1:0] w_ex_in_inst;
   logic [PC_W-1:0]   w_ex_in_pc;
   issue_tag_t        w_ex_in_tag;
   issue_tag_t        w_ex_tag;

   assign w_ex_vld  = r_state[0];
   assign w_accept  = ib_issue_vld & r_rdy & ~iu_ifu_flush;
   // Stall only matters when something sits in EX
   assign w_advance = w_ex_vld & ~iu_ifu_ex_stall;

   assign w_ib_tag.expt     = ib_issue_expt_vld;
   assign w_ib_tag.prvlg    = ib_issue_prvlg_expt_vld;
   assign w_ib_tag.ni       = ib_issue_ni;
   assign w_ib_tag.rand_vld = ib_issue_rand_vld;

   always_comb begin
      w_state_next   = r_state;
      w_ex_load      = 1'b0;
      w_skid_load    = 1'b0;
      w_ex_from_skid = 1'b0;
      if (iu_ifu_flush) begin
         // Both entries drop; payload regs keep stale data but are invalid
         w_state_next = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  w_state_next = ST_EX_ONLY;
                  w_ex_load    = 1'b1;
               end
            end
            ST_EX_ONLY: begin
               if (w_advance && w_accept) begin
                  w_ex_load    = 1'b1;
               end else if (w_advance) begin
                  w_state_next = ST_EMPTY;
               end else if (w_accept) begin
                  w_state_next = ST_FULL;
                  w_skid_load  = 1'b1;
               end
            end
            ST_FULL: begin
               // rdy is low here, so no new instruction can arrive
               if (w_advance) begin
                  w_state_next   = ST_EX_ONLY;
                  w_ex_load      = 1'b1;
                  w_ex_from_skid = 1'b1;
               end
            end
            default: w_state_next = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         r_state <= ST_EMPTY;
         r_rdy   <= 1'b1;
      end else begin
         r_state <= w_state_next;
         // Ready is precomputed from the next state so the IB sees a flop
         r_rdy   <= (w_state_next != ST_FULL);
      end
   end

   assign w_ex_in_inst = w_ex_from_skid ? w_skid_inst : ib_issue_inst;
   assign w_ex_in_pc   = w_ex_from_skid ? w_skid_pc   : ib_issue_pc;
   assign w_ex_in_tag  = w_ex_from_skid ? w_skid_tag  : w_ib_tag;

   cr_ifu_issue_entry #(
      .INST_W (INST_W),
      .PC_W   (PC_W)
   ) u_ex_entry (
      .clk    (forever_cpuclk),
      .rst    (cpurst),
      .i_load (w_ex_load),
      .i_inst (w_ex_in_inst),
      .i_pc   (w_ex_in_pc),
      .i_tag  (w_ex_in_tag),
      .o_inst (ifu_iu_ex_inst),
      .o_pc   (ifu_iu_ex_pc),
      .o_tag  (w_ex_tag)
   );

   cr_ifu_issue_entry #(
      .INST_W (INST_W),
      .PC_W   (PC_W)
   ) u_skid_entry (
      .clk    (forever_cpuclk),
      .rst    (cpurst),
      .i_load (w_skid_load),
      .i_inst (ib_issue_inst),
      .i_pc   (ib_issue_pc),
      .i_tag  (w_ib_tag),
      .o_inst (w_skid_inst),
      .o_pc   (w_skid_pc),
      .o_tag  (w_skid_tag)
   );

   assign ifu_ib_issue_rdy         = r_rdy;
   assign ifu_iu_ex_inst_vld       = w_ex_vld;
   // Tags are qualified so stale payload never leaks an exception
   assign ifu_iu_ex_expt_vld       = w_ex_vld & w_ex_tag.expt;
   assign ifu_iu_ex_prvlg_expt_vld = w_ex_vld & w_ex_tag.prvlg;
   assign ifu_iu_ex_ni             = w_ex_vld & w_ex_tag.ni;
   assign ifu_iu_ex_rand_vld       = w_ex_vld & w_ex_tag.rand_vld;

`ifdef CR_IFU_ISSUE_STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         r_stall_cnt <= '0;
      end else if (w_ex_vld && iu_ifu_ex_stall && !iu_ifu_flush &&
                   (r_stall_cnt != 32'hFFFF_FFFF)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign ifu_issue_stall_cnt = r_stall_cnt;
`else
   assign ifu_issue_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_cr_ifu_ex_issue.sv
// -----------------------------------------------------------------------------
// tb_cr_ifu_ex_issue
// Self-checking bench for cr_ifu_ex_issue. Accepted instructions are pushed to
// a scoreboard queue; the queue head is what EX must present, and it is popped
// when the IU consumes it. Ready and the stall counter are modelled alongside.
// -----------------------------------------------------------------------------
module tb_cr_ifu_ex_issue;

   localparam int INST_W = 32;
   localparam int PC_W   = 31;

   typedef struct {
      logic [INST_W-1:0] inst;
      logic [PC_W-1:0]   pc;
      logic [3:0]        tag;   // {expt, prvlg, ni, rand}
   } item_t;

   logic              clk;
   logic              rst;
   logic              ib_vld;
   logic [INST_W-1:0] ib_inst;
   logic [PC_W-1:0]   ib_pc;
   logic              ib_expt, ib_prvlg, ib_ni, ib_rand;
   logic              ib_rdy;
   logic              stall, flush;
   logic              ex_vld;
   logic [INST_W-1:0] ex_inst;
   logic [PC_W-1:0]   ex_pc;
   logic              ex_expt, ex_prvlg, ex_ni, ex_rand;
   logic [31:0]       stall_cnt;

   item_t       sb[$];
   logic        rdy_m;
   logic [31:0] cnt_m;
   int          checks;
   int          failures;
   int          cyc;

   cr_ifu_ex_issue dut (
      .forever_cpuclk           (clk),
      .cpurst                   (rst),
      .ib_issue_vld             (ib_vld),
      .ib_issue_inst            (ib_inst),
      .ib_issue_pc              (ib_pc),
      .ib_issue_expt_vld        (ib_expt),
      .ib_issue_prvlg_expt_vld  (ib_prvlg),
      .ib_issue_ni              (ib_ni),
      .ib_issue_rand_vld        (ib_rand),
      .ifu_ib_issue_rdy         (ib_rdy),
      .iu_ifu_ex_stall          (stall),
      .iu_ifu_flush             (flush),
      .ifu_iu_ex_inst_vld       (ex_vld),
      .ifu_iu_ex_inst           (ex_inst),
      .ifu_iu_ex_pc             (ex_pc),
      .ifu_iu_ex_expt_vld       (ex_expt),
      .ifu_iu_ex_prvlg_expt_vld (ex_prvlg),
      .ifu_iu_ex_ni             (ex_ni),
      .ifu_iu_ex_rand_vld       (ex_rand),
      .ifu_issue_stall_cnt      (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
      end
   endtask

   // Compare every DUT output against the model (called mid low phase)
   task automatic check_outputs();
      check_eq("ex_vld", 64'(ex_vld), 64'(sb.size() > 0));
      check_eq("ib_rdy", 64'(ib_rdy), 64'(rdy_m));
      if (sb.size() > 0) begin
         check_eq("ex_inst", 64'(ex_inst), 64'(sb[0].inst));
         check_eq("ex_pc",   64'(ex_pc),   64'(sb[0].pc));
         check_eq("ex_tags", 64'({ex_expt, ex_prvlg, ex_ni, ex_rand}), 64'(sb[0].tag));
      end else begin
         check_eq("ex_tags_idle", 64'({ex_expt, ex_prvlg, ex_ni, ex_rand}), 64'd0);
      end
      check_eq("stall_cnt", 64'(stall_cnt), 64'(cnt_m));
   endtask

   // One clock of stimulus: drive, check, update model across the edge
   task automatic cycle(input logic vld, input logic [INST_W-1:0] inst,
                        input logic [PC_W-1:0] pc, input logic [3:0] tag,
                        input logic stl, input logic fl);
      logic  adv, acc;
      item_t it;
      ib_vld   = vld;
      ib_inst  = inst;
      ib_pc    = pc;
      {ib_expt, ib_prvlg, ib_ni, ib_rand} = tag;
      stall    = stl;
      flush    = fl;
      #1;
      check_outputs();
      adv = (sb.size() > 0) && !stl;
      acc = vld && rdy_m && !fl;
`ifdef CR_IFU_ISSUE_STALL_CNT_EN
      if ((sb.size() > 0) && stl && !fl && (cnt_m != 32'hFFFF_FFFF)) cnt_m++;
`endif
      if (fl) begin
         sb.delete();
      end else begin
         if (adv) void'(sb.pop_front());
         if (acc) begin
            it.inst = inst;
            it.pc   = pc;
            it.tag  = tag;
            sb.push_back(it);
         end
      end
      @(posedge clk);
      rdy_m = (sb.size() != 2);
      $display("cyc=%0d vld=%0b inst=0x%08h stall=%0b flush=%0b acc=%0b adv=%0b depth=%0d",
               cyc, vld, inst, stl, fl, acc, adv, sb.size());
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle(input logic stl);
      cycle(1'b0, '0, '0, 4'd0, stl, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      #2;
      sb.delete();
      rdy_m = 1'b1;
      cnt_m = '0;
      check_outputs();
      check_eq("rst_inst", 64'(ex_inst), 64'd0);
      check_eq("rst_pc",   64'(ex_pc),   64'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      cyc      = 0;
      rst      = 1'b1;
      ib_vld   = 1'b0;
      ib_inst  = '0;
      ib_pc    = '0;
      {ib_expt, ib_prvlg, ib_ni, ib_rand} = 4'd0;
      stall    = 1'b0;
      flush    = 1'b0;
      rdy_m    = 1'b1;
      cnt_m    = '0;
      @(posedge clk);
      do_reset();

      // Basic single instruction, no stall
      cycle(1'b1, 32'h0000_0013, 31'h100, 4'd0, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);

      // A, B back to back; stall for 3 cycles from A's EX cycle; C offered
      cycle(1'b1, 32'hAAAA_0001, 31'h200, 4'd0, 1'b0, 1'b0);
      cycle(1'b1, 32'hBBBB_0002, 31'h202, 4'd0, 1'b1, 1'b0);
      cycle(1'b1, 32'hCCCC_0003, 31'h204, 4'd0, 1'b1, 1'b0);
      cycle(1'b1, 32'hCCCC_0003, 31'h204, 4'd0, 1'b1, 1'b0);
      cycle(1'b1, 32'hCCCC_0003, 31'h204, 4'd0, 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 4'd0, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);

      // FULL then flush with a new input offered
      cycle(1'b1, 32'h1111_0001, 31'h300, 4'd0, 1'b0, 1'b0);
      cycle(1'b1, 32'h2222_0002, 31'h302, 4'd0, 1'b1, 1'b0);
      cycle(1'b1, 32'h3333_0003, 31'h304, 4'd0, 1'b1, 1'b1);
      idle(1'b0);
      idle(1'b0);

      // Tagged instruction through the skid path, then a clean one
      cycle(1'b1, 32'h4444_0001, 31'h400, 4'd0,     1'b0, 1'b0);
      cycle(1'b1, 32'h5555_0002, 31'h402, 4'b1010,  1'b1, 1'b0);
      cycle(1'b0, '0, '0, 4'd0, 1'b1, 1'b0);
      cycle(1'b1, 32'h6666_0003, 31'h404, 4'd0,     1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);
      idle(1'b0);

      // Stall while EMPTY: input still accepted
      cycle(1'b1, 32'h7777_0001, 31'h500, 4'b0101, 1'b1, 1'b0);
      idle(1'b0);
      idle(1'b0);

      // Stall counter: 5 stalled EX cycles then a flush-cycle stall
      do_reset();
      cycle(1'b1, 32'h8888_0001, 31'h600, 4'd0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) idle(1'b1);
      cycle(1'b0, '0, '0, 4'd0, 1'b1, 1'b1);
      idle(1'b0);
`ifdef CR_IFU_ISSUE_STALL_CNT_EN
      check_eq("cnt_five", 64'(stall_cnt), 64'd5);
`else
      check_eq("cnt_zero", 64'(stall_cnt), 64'd0);
`endif

      // Random traffic
      for (int i = 0; i < 200; i++) begin
         cycle(($urandom % 4) != 0, $urandom, 31'($urandom), 4'($urandom),
               ($urandom % 3) == 0, ($urandom % 16) == 0);
      end

      // Asynchronous reset in the middle of traffic
      cycle(1'b1, 32'h9999_0001, 31'h700, 4'b1111, 1'b0, 1'b0);
      cycle(1'b1, 32'h9999_0002, 31'h702, 4'b1111, 1'b1, 1'b0);
      rst = 1'b1;
      #2;
      sb.delete();
      rdy_m = 1'b1;
      cnt_m = '0;
      check_outputs();
      check_eq("arst_inst", 64'(ex_inst), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      cycle(1'b1, 32'hDEAD_0001, 31'h800, 4'b0011, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
